// File: rtl/axis_egress_if.sv
// AXI4-Stream channel bundle used by axis_egress for both its internal (slave)
// and external (master) ports.
interface axis_egress_if #(
    parameter int DATA_WIDTH = 64
) ();
    // valid/ready: a beat transfers on a rising edge where tvalid and tready
    // are both 1; the source holds tdata/tlast stable while tvalid && !tready.
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/axis_egress.sv
// Registered AXI4-Stream egress adapter with a two-entry (OUT + SKID) skid buffer.
// Beat/frame statistics are compiled in only when AXIS_EGRESS_STATS_EN is defined.
module axis_egress #(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    axis_egress_if.slave         axis,
    axis_egress_if.master        m_axis,
    output logic                 beat_sent,
    output logic                 frame_done,
    output logic [CNT_WIDTH-1:0] frame_len,
    output logic [31:0]          frame_cnt,
    output logic [1:0]           o_dbg_state
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_SKID  = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_last;
    logic [DATA_WIDTH-1:0] r_skid_data;
    logic                  r_skid_last;
    logic                  w_in_acc;
    logic                  w_out_acc;

    assign w_in_acc  = axis.tvalid && r_in_ready;
    assign w_out_acc = r_out_valid && m_axis.tready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_acc) w_state_nxt = ST_FULL;
            end
            ST_FULL: begin
                if (w_in_acc && !w_out_acc)      w_state_nxt = ST_SKID;
                else if (!w_in_acc && w_out_acc) w_state_nxt = ST_EMPTY;
            end
            ST_SKID: begin
                if (w_out_acc) w_state_nxt = ST_FULL;
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // Ready and valid are both derived from the next state so they stay registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt != ST_SKID);
            r_out_valid <= (w_state_nxt != ST_EMPTY);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_skid_data <= '0;
            r_skid_last <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_acc) begin
                        r_out_data <= axis.tdata;
                        r_out_last <= axis.tlast;
                    end
                end
                ST_FULL: begin
                    if (w_in_acc && w_out_acc) begin
                        r_out_data <= axis.tdata;
                        r_out_last <= axis.tlast;
                    end else if (w_in_acc) begin
                        r_skid_data <= axis.tdata;
                        r_skid_last <= axis.tlast;
                    end
                end
                ST_SKID: begin
                    if (w_out_acc) begin
                        r_out_data <= r_skid_data;
                        r_out_last <= r_skid_last;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign axis.tready   = r_in_ready;
    assign m_axis.tvalid = r_out_valid;
    assign m_axis.tdata  = r_out_data;
    assign m_axis.tlast  = r_out_last;
    assign beat_sent     = w_out_acc;
    assign o_dbg_state   = r_state;

`ifdef AXIS_EGRESS_STATS_EN
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [CNT_WIDTH-1:0] r_beat_cnt;
    logic [CNT_WIDTH-1:0] r_frame_len;
    logic [31:0]          r_frame_cnt;
    logic                 r_frame_done;

    // beat_cnt counts the non-last beats already sent, so the frame length is +1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_cnt   <= '0;
            r_frame_len  <= '0;
            r_frame_cnt  <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_out_acc) begin
                if (r_out_last) begin
                    r_frame_len  <= (r_beat_cnt == CNT_MAX) ? CNT_MAX : r_beat_cnt + 1'b1;
                    r_beat_cnt   <= '0;
                    r_frame_cnt  <= r_frame_cnt + 32'd1;
                    r_frame_done <= 1'b1;
                end else if (r_beat_cnt != CNT_MAX) begin
                    r_beat_cnt <= r_beat_cnt + 1'b1;
                end
            end
        end
    end

    assign frame_done = r_frame_done;
    assign frame_len  = r_frame_len;
    assign frame_cnt  = r_frame_cnt;
`else
    assign frame_done = 1'b0;
    assign frame_len  = '0;
    assign frame_cnt  = '0;
`endif

endmodule

// File: tb/tb_axis_egress.sv
// Bench for axis_egress: randomized frames checked against a queue-based model of
// the buffered beats, plus a CNT_WIDTH=2 instance for frame_len saturation.
module tb_axis_egress;

`ifdef AXIS_EGRESS_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    localparam int DW = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    axis_egress_if #(.DATA_WIDTH(DW)) s0 ();
    axis_egress_if #(.DATA_WIDTH(DW)) m0 ();
    axis_egress_if #(.DATA_WIDTH(DW)) s1 ();
    axis_egress_if #(.DATA_WIDTH(DW)) m1 ();

    logic        beat_sent0, frame_done0, beat_sent1, frame_done1;
    logic [15:0] frame_len0;
    logic [1:0]  frame_len1;
    logic [31:0] frame_cnt0, frame_cnt1;
    logic [1:0]  dbg_state0, dbg_state1;

    axis_egress #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .axis        (s0),
        .m_axis      (m0),
        .beat_sent   (beat_sent0),
        .frame_done  (frame_done0),
        .frame_len   (frame_len0),
        .frame_cnt   (frame_cnt0),
        .o_dbg_state (dbg_state0)
    );

    axis_egress #(.DATA_WIDTH(DW), .CNT_WIDTH(2)) dut_small (
        .clk         (clk),
        .rst_n       (rst_n),
        .axis        (s1),
        .m_axis      (m1),
        .beat_sent   (beat_sent1),
        .frame_done  (frame_done1),
        .frame_len   (frame_len1),
        .frame_cnt   (frame_cnt1),
        .o_dbg_state (dbg_state1)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard and reference model state
    int          checks = 0;
    int          errors = 0;
    logic [DW:0] exp_q[$];
    logic        exp_ready = 1'b0;
    logic        exp_done = 1'b0;
    int          exp_len = 0;
    int          exp_len_s = 0;
    int          exp_cnt = 0;
    int          frame_beats = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int sat(input int n, input int max_v);
        return (n > max_v) ? max_v : n;
    endfunction

    // One clock cycle: drive inputs, compare outputs, then advance the model
    // to what the coming rising edge will do.
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic l,
                         input logic mr, output logic in_acc);
        logic [DW:0] head;
        logic        out_acc;
        @(negedge clk);
        s0.tvalid = v;  s0.tdata = d;  s0.tlast = l;
        s1.tvalid = v;  s1.tdata = d;  s1.tlast = l;
        m0.tready = mr; m1.tready = mr;
        #1;
        check("axis_tready", 64'(s0.tready), 64'(exp_ready));
        check("m_tvalid", 64'(m0.tvalid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            head = exp_q[0];
            check("m_tdata", m0.tdata, head[DW-1:0]);
            check("m_tlast", 64'(m0.tlast), 64'(head[DW]));
        end
        check("beat_sent", 64'(beat_sent0), 64'((exp_q.size() != 0) && mr));
        check("frame_done", 64'(frame_done0), 64'(STATS ? exp_done : 1'b0));
        check("frame_len", 64'(frame_len0), 64'(STATS ? exp_len : 0));
        check("frame_cnt", 64'(frame_cnt0), 64'(STATS ? exp_cnt : 0));
        check("small_frame_len", 64'(frame_len1), 64'(STATS ? exp_len_s : 0));
        check("small_frame_cnt", 64'(frame_cnt1), 64'(STATS ? exp_cnt : 0));
        check("small_frame_done", 64'(frame_done1), 64'(STATS ? exp_done : 1'b0));

        in_acc  = v && exp_ready;
        out_acc = (exp_q.size() != 0) && mr;
        exp_done = 1'b0;
        if (out_acc) begin
            head = exp_q.pop_front();
            frame_beats++;
            if (head[DW]) begin
                exp_len     = sat(frame_beats, 65535);
                exp_len_s   = sat(frame_beats, 3);
                exp_cnt     = exp_cnt + 1;
                exp_done    = 1'b1;
                frame_beats = 0;
            end
        end
        if (in_acc) exp_q.push_back({l, d});
        exp_ready = (exp_q.size() != 2);
    endtask

    // driver tasks
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        s0.tvalid = 1'b0; s1.tvalid = 1'b0;
        m0.tready = 1'b0; m1.tready = 1'b0;
        #1;
        check("rst_tready", 64'(s0.tready), 64'(0));
        check("rst_tvalid", 64'(m0.tvalid), 64'(0));
        check("rst_tdata", m0.tdata, 64'(0));
        check("rst_tlast", 64'(m0.tlast), 64'(0));
        check("rst_frame_done", 64'(frame_done0), 64'(0));
        check("rst_frame_len", 64'(frame_len0), 64'(0));
        check("rst_frame_cnt", 64'(frame_cnt0), 64'(0));
        check("rst_small_len", 64'(frame_len1), 64'(0));
        exp_q.delete();
        exp_done = 1'b0;
        exp_len = 0; exp_len_s = 0; exp_cnt = 0; frame_beats = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_tready", 64'(s0.tready), 64'(0));
        exp_ready = 1'b1;
    endtask

    task automatic send_frame(input int n, input logic [DW-1:0] base,
                              input bit rnd, input bit with_last);
        int   idx = 0;
        int   guard = 0;
        logic acc;
        logic v, mr;
        while (idx < n && guard < 2000) begin
            v  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            mr = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cycle(v, base + DW'(idx), with_last && (idx == n - 1), mr, acc);
            if (acc) idx++;
            guard++;
        end
        check("send_done", 64'(idx), 64'(n));
    endtask

    task automatic drain(input bit rnd);
        int   guard = 0;
        logic acc;
        while (exp_q.size() != 0 && guard < 500) begin
            cycle(1'b0, '0, 1'b0, rnd ? 1'($urandom_range(0, 1)) : 1'b1, acc);
            guard++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'(0));
        repeat (2) cycle(1'b0, '0, 1'b0, 1'b1, acc);
    endtask

    initial begin
        s0.tvalid = 1'b0; s0.tdata = '0; s0.tlast = 1'b0;
        s1.tvalid = 1'b0; s1.tdata = '0; s1.tlast = 1'b0;
        m0.tready = 1'b0; m1.tready = 1'b0;

        do_reset();

        send_frame(1, 64'h11, 1'b0, 1'b1);
        drain(1'b0);

        send_frame(8, 64'd1, 1'b0, 1'b1);
        drain(1'b0);

        send_frame(8, 64'd1, 1'b1, 1'b1);
        drain(1'b1);

        send_frame(6, 64'h100, 1'b0, 1'b1);
        drain(1'b0);

        send_frame(3, 64'h200, 1'b0, 1'b0);
        do_reset();
        send_frame(2, 64'h300, 1'b0, 1'b1);
        drain(1'b0);

        for (int f = 0; f < 25; f++) begin
            send_frame(int'($urandom_range(1, 10)), {$urandom, $urandom}, 1'b1, 1'b1);
            if ($urandom_range(0, 2) == 0) drain(1'b1);
        end
        drain(1'b1);

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
